// File: rtl/csa_resolve_pkg.sv
// Shared state encodings and sizing helpers for the carry-save resolver.
// Any block that decodes resolver state imports this package.
package csa_resolve_pkg;

  localparam logic [1:0] CSA_IDLE = 2'd0;
  localparam logic [1:0] CSA_RUN  = 2'd1;
  localparam logic [1:0] CSA_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = CSA_IDLE,
    RUN  = CSA_RUN,
    DONE = CSA_DONE
  } csa_state_e;

  // A counter always needs at least one bit, even when there is only one digit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the resolver chains these to build a digit adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_resolve.sv
// Resolves a carry-save pair (s_in, c_in) into a binary sum.
// The pair is added DIGIT bits per cycle, least-significant digit first.
module csa_resolve
  import csa_resolve_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int DIGIT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] s_in,
  input  logic [BITS-1:0] c_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] sum,
  output logic            cout
);

  localparam int NDIG = BITS / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  csa_state_e state, next_state;

  logic [BITS-1:0]  s_reg, c_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d_s, d_c, d_sum;
  logic [DIGIT:0]   chain;
  logic             last_digit;

  assign last_digit = (cnt == LAST);
  assign d_s        = s_reg[int'(cnt)*DIGIT +: DIGIT];
  assign d_c        = c_reg[int'(cnt)*DIGIT +: DIGIT];
  assign chain[0]   = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a   (d_s[i]),
      .b   (d_c[i]),
      .cin (chain[i]),
      .s   (d_sum[i]),
      .cout(chain[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)   next_state = RUN;
      RUN:     if (last_digit) next_state = DONE;
      DONE:    if (out_ready)  next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // cnt is left at LAST after the final digit; it is cleared on the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg <= '0;
      c_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_reg <= s_in;
            c_reg <= c_in;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum[int'(cnt)*DIGIT +: DIGIT] <= d_sum;
          carry <= chain[DIGIT];
          if (last_digit) cout <= chain[DIGIT];
          else            cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolve.sv
// Bench for csa_resolve: directed cases on an 8/2 instance plus random
// lanes at DIGIT = 2, 1 and 8 checked against plain s + c arithmetic.
module tb_csa_resolve;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  logic       rst_n, in_valid, in_ready, out_valid, out_ready, cout;
  logic [7:0] s_in, c_in, sum;

  csa_resolve #(.BITS(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s_in(s_in), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  // Drives one pair through the directed instance, stalling DONE for 'stall' cycles
  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] c, input logic [8:0] expected,
                               input int stall, input string tag);
    int cycles;
    @(negedge clk);
    in_valid = 1'b1; s_in = s; c_in = c;
    cycles = 0;
    while (!in_ready && cycles < 10) begin @(negedge clk); cycles++; end
    checkOutput({tag, "_accept"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    s_in = ~s; c_in = ~c;
    checkOutput({tag, "_busy"}, in_ready, 0);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(negedge clk); cycles++;
      s_in = 8'($urandom); c_in = 8'($urandom);
    end
    in_valid = 1'b0;
    checkOutput({tag, "_latency"}, cycles, 4);
    checkOutput({tag, "_result"}, {cout, sum}, expected);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      s_in = 8'($urandom); c_in = 8'($urandom);
      @(negedge clk);
      checkOutput({tag, "_hold_result"}, {cout, sum}, expected);
      checkOutput({tag, "_hold_valid"}, out_valid, 1);
      checkOutput({tag, "_hold_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, in_ready, 1);
    checkOutput({tag, "_idle_valid"}, out_valid, 0);
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int D    = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
    localparam int NDIG = 8 / D;

    logic       l_rst_n, l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_cout;
    logic [7:0] l_s, l_c, l_sum;
    bit         done = 1'b0;

    csa_resolve #(.BITS(8), .DIGIT(D)) u_dut (
      .clk(clk), .rst_n(l_rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
      .s_in(l_s), .c_in(l_c), .out_valid(l_out_valid), .out_ready(l_out_ready),
      .sum(l_sum), .cout(l_cout)
    );

    initial begin
      logic [7:0] s, c;
      logic [8:0] expected;
      int         cycles;
      l_rst_n = 1'b0; l_in_valid = 1'b0; l_out_ready = 1'b0; l_s = '0; l_c = '0;
      repeat (3) @(negedge clk);
      l_rst_n = 1'b1;
      for (int n = 0; n < 1000; n++) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          l_s = 8'($urandom); l_c = 8'($urandom);
        end
        s = 8'($urandom); c = 8'($urandom);
        expected = {1'b0, s} + {1'b0, c};
        @(negedge clk);
        l_in_valid = 1'b1; l_s = s; l_c = c;
        cycles = 0;
        while (!l_in_ready && cycles < 10) begin @(negedge clk); cycles++; end
        checkOutput($sformatf("d%0d_accept", D), l_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        l_in_valid = 1'($urandom); l_s = 8'($urandom); l_c = 8'($urandom);
        cycles = 0;
        while (!l_out_valid && cycles < NDIG + 5) begin
          @(negedge clk); cycles++;
          l_in_valid = 1'($urandom); l_s = 8'($urandom); l_c = 8'($urandom);
        end
        l_in_valid = 1'b0;
        checkOutput($sformatf("d%0d_latency", D), cycles, NDIG);
        checkOutput($sformatf("d%0d_result", D), {l_cout, l_sum}, expected);
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          checkOutput($sformatf("d%0d_hold", D), {l_cout, l_sum}, expected);
        end
        l_out_ready = 1'b1;
        @(negedge clk);
        l_out_ready = 1'b0;
        checkOutput($sformatf("d%0d_idle", D), l_in_ready, 1);
      end
      done = 1'b1;
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s_in = '0; c_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", {cout, sum}, 0);
    rst_n = 1'b1;

    applyStimulus(8'h0F, 8'h01, 9'h010, 0, "carry_chain");
    applyStimulus(8'hFF, 8'h01, 9'h100, 0, "overflow");
    applyStimulus(8'hAA, 8'h55, 9'h0FF, 0, "no_carry");
    applyStimulus(8'h81, 8'h7F, 9'h100, 3, "stall");

    // Abort in the second RUN cycle
    @(negedge clk);
    in_valid = 1'b1; s_in = 8'h0F; c_in = 8'h01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_result", {cout, sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("abort_no_result", out_valid, 0);
    end
    applyStimulus(8'h03, 8'h05, 9'h008, 1, "post_reset");

    waited = 0;
    while (!(lane[0].done && lane[1].done && lane[2].done) && waited < 60000) begin
      @(negedge clk); waited++;
    end
    checkOutput("lanes_finished", {lane[2].done, lane[1].done, lane[0].done}, 3'b111);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/csa_resolve.md
CSA_RESOLVE -- requirements
Module: csa_resolve

Interface
REQ-001 SHALL have parameter BITS, default 8: operand width and result width.
REQ-002 SHALL have parameter DIGIT, default 2: bits resolved per cycle; BITS SHALL be a multiple of DIGIT.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state changes occur on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  the redundant operand pair on s_in/c_in is valid.
REQ-007 in_ready  output  1  the block can accept a new operand pair.
REQ-008 s_in  input  BITS  sum vector of the carry-save pair.
REQ-009 c_in  input  BITS  carry vector of the carry-save pair, already weight-aligned (bit i has weight 2^i).
REQ-010 out_valid  output  1  sum/cout hold a resolved result.
REQ-011 out_ready  input  1  the consumer accepts the result.
REQ-012 sum  output  BITS  (s_in + c_in) mod 2^BITS.
REQ-013 cout  output  1  carry out of bit BITS-1.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on in_valid & in_ready, SHALL latch s_in and c_in, clear the running carry and digit counter, and go to RUN.
REQ-017 RUN: each cycle SHALL add DIGIT bits of the latched pair, least-significant digit first, plus the running carry; SHALL store DIGIT result bits and update the running carry.
REQ-018 RUN SHALL last exactly BITS/DIGIT cycles; after the last digit SHALL go to DONE with cout equal to the final carry.
REQ-019 Latency: if a pair is accepted on edge k, out_valid SHALL be 1 after edge k+BITS/DIGIT.
REQ-020 DONE: sum and cout SHALL hold stable while out_ready is 0; on out_ready SHALL return to IDLE.
REQ-021 IDLE is not entered and a new pair is not accepted in the same cycle as the DONE handshake; the next acceptance is at the earliest on the following edge.
REQ-022 s_in and c_in changes during RUN or DONE SHALL NOT affect the result.
REQ-023 Overflow SHALL wrap modulo 2^BITS, with the lost bit reported on cout.
REQ-024 DIGIT equal to BITS SHALL give single-cycle RUN; DIGIT equal to 1 SHALL give bit-serial operation.

Reset
REQ-025 While rst_n is 0: state SHALL be IDLE, and sum, cout, out_valid, the running carry and the digit counter SHALL be 0.
REQ-026 While rst_n is 0, in_ready SHALL be 1.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered.

Structure
REQ-028 The state encodings shall be shared localparams in a common csa defines include, not private to this module.
REQ-029 The per-digit adder SHALL be a generate chain of DIGIT instances of the existing full_adder sub-module, with carry rippling within the digit.
REQ-030 The digit counter width SHALL be clog2(BITS/DIGIT) with a minimum of 1.

Verification (BITS=8, DIGIT=2 unless stated)
REQ-031 s_in=0x0F, c_in=0x01 accepted at edge k -> out_valid after edge k+4, sum=0x10, cout=0.
REQ-032 s_in=0xFF, c_in=0x01 -> sum=0x00, cout=1; s_in=0xAA, c_in=0x55 -> sum=0xFF, cout=0.
REQ-033 out_ready held 0 for 3 cycles in DONE -> sum/cout/out_valid stable and in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-034 rst_n pulsed low during the 2nd RUN cycle -> immediate IDLE with all outputs 0; the next pair (0x03, 0x05) -> sum=0x08.
REQ-035 Parameter sweep with DIGIT=1 (latency 8) and DIGIT=8 (latency 1), using 1000 random pairs with random in_valid/out_ready -> every result equals s_in+c_in as a 9-bit value {cout,sum}.
